// File: rtl/pipeline_mdu_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 opcodes and FSM encodings.
package pipeline_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_t;

  // bit 2 of funct3 separates the divide family from the multiply family
  localparam int MDU_DIV_BIT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/pipeline_mdu_divider.sv
// Iterative radix-2 restoring divider with RISC-V divide-by-zero and overflow handling.
module mdu_divider
  import pipeline_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  mdu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_ITER = 2'd1;
  localparam logic [1:0] PH_FIX  = 2'd2;
  localparam logic [1:0] PH_SPEC = 2'd3;

  logic [1:0]      phase;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, spec_q;
  logic            neg_q, neg_r, want_rem;

  logic            kick, is_signed, sa, sb, div_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_val, fix_val;
  logic [XLEN:0]   shifted, diff;

  always_comb begin
    kick      = start && op[MDU_DIV_BIT];
    is_signed = ~op[0];
    sa        = is_signed & a[XLEN-1];
    sb        = is_signed & b[XLEN-1];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
    div_zero  = (b == '0);
    ovf       = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    // op[1] selects remainder; zero divisor and signed overflow bypass the iterations
    if (div_zero) spec_val = op[1] ? a : '1;
    else          spec_val = op[1] ? '0 : a;
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, dvs_q};
    if (want_rem) fix_val = neg_r ? -rem_q : rem_q;
    else          fix_val = neg_q ? -quo_q : quo_q;
    done      = (phase == PH_FIX) || (phase == PH_SPEC);
    result    = (phase == PH_SPEC) ? spec_q : fix_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      spec_q   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
    end else if (kill) begin
      phase <= PH_IDLE;
    end else begin
      case (phase)
        PH_IDLE: if (kick) begin
          rem_q    <= '0;
          quo_q    <= mag_a;
          dvs_q    <= mag_b;
          spec_q   <= spec_val;
          neg_q    <= sa ^ sb;
          neg_r    <= sa;
          want_rem <= op[1];
          cnt      <= '0;
          phase    <= (div_zero || ovf) ? PH_SPEC : PH_ITER;
        end
        PH_ITER: begin
          if (!diff[XLEN]) begin
            rem_q <= diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q <= shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) phase <= PH_FIX;
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_mdu.sv
// RV32M multiply/divide unit: staged multiply inline, iterative divide in mdu_divider.
module pipeline_mdu
  import pipeline_mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int PIPE_N = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam int MCW    = $clog2(MUL_STAGES + 1);
  localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_STAGES - 1);

  logic [1:0]        state;
  logic [MCW-1:0]    cnt;
  logic [XLEN-1:0]   a_q, b_q;
  logic [1:0]        mop_q;
  logic [TAG_W-1:0]  tag_q;
  logic [2*XLEN-1:0] pipe [PIPE_N];
  logic [2*XLEN-1:0] stage_in [MUL_STAGES];
  logic [2*XLEN-1:0] ext_a, ext_b, mul_last;
  logic [XLEN-1:0]   mul_res, div_res;
  logic              sign_a, sign_b, accept, div_done;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  assign accept     = req_valid && req_ready && !flush;

  // mulh/mulhsu treat rs1 as signed; only mulh treats rs2 as signed
  always_comb begin
    sign_a   = ((mop_q == 2'd1) || (mop_q == 2'd2)) && a_q[XLEN-1];
    sign_b   = (mop_q == 2'd1) && b_q[XLEN-1];
    ext_a    = {{XLEN{sign_a}}, a_q};
    ext_b    = {{XLEN{sign_b}}, b_q};
    stage_in[0] = ext_a * ext_b;
    for (int k = 1; k < MUL_STAGES; k++) stage_in[k] = pipe[k-1];
    mul_last = stage_in[MUL_STAGES-1];
    mul_res  = (mop_q == 2'd0) ? mul_last[XLEN-1:0] : mul_last[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < PIPE_N; j++) begin
      if (rst) pipe[j] <= '0;
      else     pipe[j] <= stage_in[j];
    end
  end

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk    (clk),
    .rst    (rst),
    .kill   (flush),
    .start  (accept),
    .op     (mdu_op_t'(req_op)),
    .a      (req_a),
    .b      (req_b),
    .done   (div_done),
    .result (div_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mop_q     <= '0;
      tag_q     <= '0;
      resp_data <= '0;
      resp_tag  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          a_q   <= req_a;
          b_q   <= req_b;
          mop_q <= req_op[1:0];
          tag_q <= req_tag;
          cnt   <= '0;
          state <= req_op[MDU_DIV_BIT] ? ST_DIV : ST_MUL;
        end
        ST_MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            resp_data <= mul_res;
            resp_tag  <= tag_q;
            state     <= ST_DONE;
          end
        end
        ST_DIV: if (div_done) begin
          resp_data <= div_res;
          resp_tag  <= tag_q;
          state     <= ST_DONE;
        end
        default: if (resp_ready) state <= ST_IDLE;
      endcase
      // a flush always returns to idle; a same-cycle DONE handshake has already completed
      if (flush) state <= ST_IDLE;
    end
  end

  a_ready_excl: assert property (@(posedge clk) disable iff (rst) !(req_ready && resp_valid));
  a_resp_hold: assert property (@(posedge clk)
    (!rst && !flush && resp_valid && !resp_ready) |=> ($stable(resp_data) && $stable(resp_tag)));

endmodule

// File: tb/tb_pipeline_mdu.sv
// Directed self-checking bench for pipeline_mdu at 32-bit/2-stage and 16-bit/1-stage configurations.
module tb_pipeline_mdu;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, resp_data;
  logic [4:0]  req_tag, resp_tag;

  logic        s_rst, s_flush, s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [2:0]  s_req_op;
  logic [15:0] s_req_a, s_req_b, s_resp_data;
  logic [4:0]  s_req_tag, s_resp_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_mdu #(.XLEN(32), .MUL_STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag)
  );

  pipeline_mdu #(.XLEN(16), .MUL_STAGES(1), .TAG_W(5)) dut16 (
    .clk(clk), .rst(s_rst), .flush(s_flush), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_op(s_req_op), .req_a(s_req_a), .req_b(s_req_b), .req_tag(s_req_tag),
    .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_data(s_resp_data), .resp_tag(s_resp_tag)
  );

  // drives one request, returns the edge count to resp_valid (999 on timeout) and the response
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] d, output logic [4:0] t,
                       output int lat);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 999; d = 'x; t = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin lat = k; break; end
    end
    if (lat != 999) begin
      d = resp_data; t = resp_tag;
      resp_ready = 1'b1;
      @(posedge clk); #1 resp_ready = 1'b0;
    end
  endtask

  task automatic do_op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] d, output int lat);
    @(negedge clk);
    s_req_op = op; s_req_a = a; s_req_b = b; s_req_tag = 5'd3; s_req_valid = 1'b1;
    @(posedge clk); #1 s_req_valid = 1'b0;
    lat = 999; d = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (s_resp_valid) begin lat = k; break; end
    end
    if (lat != 999) begin
      d = s_resp_data;
      s_resp_ready = 1'b1;
      @(posedge clk); #1 s_resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; s_rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_resp_data got=%h exp=0", resp_data); end
    checks++; if (resp_tag !== 5'h0) begin failures++; $display("[TB] FAIL reset_resp_tag got=%h exp=0", resp_tag); end
  endtask

  task automatic test_mul();
    logic [2:0]  ops  [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] va   [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb   [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vexp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] d; logic [4:0] t; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], va[i], vb[i], 5'(i + 5), d, t, lat);
      checks++; if (d !== vexp[i]) begin failures++; $display("[TB] FAIL mul_data[%0d] got=%h exp=%h", i, d, vexp[i]); end
      checks++; if (lat != 2) begin failures++; $display("[TB] FAIL mul_latency[%0d] got=%0d exp=2", i, lat); end
      checks++; if (t !== 5'(i + 5)) begin failures++; $display("[TB] FAIL mul_tag[%0d] got=%0d exp=%0d", i, t, i + 5); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mul_ready_after[%0d] got=%b exp=1", i, req_ready); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] va   [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] vb   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] vexp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic [31:0] d; logic [4:0] t; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], va[i], vb[i], 5'd17, d, t, lat);
      checks++; if (d !== vexp[i]) begin failures++; $display("[TB] FAIL div_data[%0d] got=%h exp=%h", i, d, vexp[i]); end
      checks++; if (lat != 33) begin failures++; $display("[TB] FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops  [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] va   [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] vb   [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vexp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    logic [31:0] d; logic [4:0] t; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], va[i], vb[i], 5'd2, d, t, lat);
      checks++; if (d !== vexp[i]) begin failures++; $display("[TB] FAIL special_data[%0d] got=%h exp=%h", i, d, vexp[i]); end
      checks++; if (lat != 1) begin failures++; $display("[TB] FAIL special_latency[%0d] got=%0d exp=1", i, lat); end
    end
  endtask

  task automatic test_backpressure();
    int seen = 0;
    @(negedge clk);
    req_op = 3'd0; req_a = 32'd6; req_b = 32'd7; req_tag = 5'd9; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int k = 0; k < 10 && !resp_valid; k++) begin @(posedge clk); #1; end
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_timeout got=%b exp=1", resp_valid); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (resp_data !== 32'd42 || resp_tag !== 5'd9 || req_ready !== 1'b0 || resp_valid !== 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("[TB] FAIL bp_hold got=%0d bad cycles exp=0 (data=%h tag=%0d)", seen, resp_data, resp_tag); end
    resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid got=%b exp=0", resp_valid); end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    req_op = 3'd0; req_a = 32'd2; req_b = 32'd2; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_wins_idle got=%b exp=1", req_ready); end
  endtask

  // use_rst selects reset instead of flush as the kill source
  task automatic test_kill(input bit use_rst);
    logic [31:0] d; logic [4:0] t; int lat; int seen = 0;
    @(negedge clk);
    req_op = 3'd5; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd4; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk); #1 rst = 1'b0; flush = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL kill_ready[%0d] got=%b exp=1", use_rst, req_ready); end
    if (use_rst) begin
      checks++; if (resp_data !== 32'h0) begin failures++; $display("[TB] FAIL rst_clears_data got=%h exp=0", resp_data); end
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("[TB] FAIL kill_no_resp[%0d] got=%0d exp=0", use_rst, seen); end
    do_op(3'd0, 32'd3, 32'd4, 5'd8, d, t, lat);
    checks++; if (d !== 32'd12) begin failures++; $display("[TB] FAIL kill_next_mul[%0d] got=%h exp=%h", use_rst, d, 32'd12); end
    checks++; if (lat != 2) begin failures++; $display("[TB] FAIL kill_next_lat[%0d] got=%0d exp=2", use_rst, lat); end
  endtask

  task automatic test_param16();
    logic [15:0] d; int lat;
    do_op16(3'd3, 16'hFFFF, 16'hFFFF, d, lat);
    checks++; if (d !== 16'hFFFE) begin failures++; $display("[TB] FAIL p16_mulhu got=%h exp=fffe", d); end
    checks++; if (lat != 1) begin failures++; $display("[TB] FAIL p16_mul_lat got=%0d exp=1", lat); end
    do_op16(3'd5, 16'h8000, 16'd3, d, lat);
    checks++; if (d !== 16'h2AAA) begin failures++; $display("[TB] FAIL p16_divu got=%h exp=2aaa", d); end
    checks++; if (lat != 17) begin failures++; $display("[TB] FAIL p16_div_lat got=%0d exp=17", lat); end
  endtask

  initial begin
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    s_flush = 1'b0; s_req_valid = 1'b0; s_resp_ready = 1'b0;
    s_req_op = '0; s_req_a = '0; s_req_b = '0; s_req_tag = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush_idle();
    test_kill(1'b0);
    test_kill(1'b1);
    test_param16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
